// File: rtl/kitt_scanner_if.sv
// kitt_scanner_if: CPU memory-bus connection for the kitt_scanner peripheral.
//   address_in     byte address (only [3:2] decoded by the peripheral)
//   sel_in         peripheral selected this cycle
//   write_mask_in  per-byte write enables, 0000 = read
//   write_value_in write data
//   read_value_out read data, combinational, 0 when not selected
//   ready_out      mirrors sel_in (zero wait states)
// master: the CPU side; slave: the peripheral side.
interface kitt_scanner_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;

  modport master (
    output address_in,
    output sel_in,
    output write_mask_in,
    output write_value_in,
    input  read_value_out,
    input  ready_out
  );

  modport slave (
    input  address_in,
    input  sel_in,
    input  write_mask_in,
    input  write_value_in,
    output read_value_out,
    output ready_out
  );
endinterface

// File: rtl/kitt_scanner.sv
// kitt_scanner: memory-mapped LED scanner. A WIDTH-bit pattern is bounced or
// rotated across display_out once per programmable tick (PRESCALER+1 cycles).
// Ports:
//   clk          sole clock
//   reset        synchronous, active-high
//   display_out  live LED pattern (registered)
//   bus          slave side of kitt_scanner_if
// Registers by address[3:2]: 0 PRESCALER, 1 CTRL {MODE[2:1], EN[0]},
// 2 PATTERN, 3 STATUS {STEPS[31:16], DIR[0]} (any write clears STEPS).
module kitt_scanner #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned RESET_PRESCALER = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] display_out,
  kitt_scanner_if.slave    bus
);

  localparam logic [1:0] ModeBounce = 2'd0;
  localparam logic [1:0] ModeRotL   = 2'd1;
  localparam logic [1:0] ModeRotR   = 2'd2;
  localparam logic [1:0] ModeHold   = 2'd3;

  logic [31:0]      r_prescaler;
  logic             r_en;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_pattern;
  logic             r_dir;
  logic [15:0]      r_steps;
  logic [31:0]      r_q;

  logic [1:0]       w_addr;
  logic             w_wr;
  logic             w_wr_presc;
  logic             w_wr_ctrl;
  logic             w_wr_pat;
  logic             w_wr_stat;
  logic             w_tick;
  logic             w_en_clear;
  logic [31:0]      w_presc_new;
  logic [WIDTH-1:0] w_pat_new;
  logic [WIDTH-1:0] w_pat_shift;
  logic             w_dir_shift;
  logic [31:0]      w_pat_ext;
  logic             w_unused_addr;

  assign w_addr        = bus.address_in[3:2];
  assign w_unused_addr = ^{bus.address_in[31:4], bus.address_in[1:0]};
  assign w_wr          = bus.sel_in & (|bus.write_mask_in);
  assign w_wr_presc    = w_wr && (w_addr == 2'd0);
  assign w_wr_ctrl     = w_wr && (w_addr == 2'd1);
  assign w_wr_pat      = w_wr && (w_addr == 2'd2);
  assign w_wr_stat     = w_wr && (w_addr == 2'd3);
  assign w_tick        = r_en && (r_q >= r_prescaler);
  // Writing EN=0 zeroes the tick counter on the same edge.
  assign w_en_clear    = w_wr_ctrl && bus.write_mask_in[0] && !bus.write_value_in[0];

  assign display_out   = r_pattern;
  assign bus.ready_out = bus.sel_in;

  // Byte-lane merge of write data into PRESCALER and PATTERN.
  always_comb begin
    w_presc_new = r_prescaler;
    for (int i = 0; i < 4; i++) begin
      if (bus.write_mask_in[i]) w_presc_new[8*i +: 8] = bus.write_value_in[8*i +: 8];
    end
    w_pat_new = r_pattern;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bus.write_mask_in[i/8]) w_pat_new[i] = bus.write_value_in[i];
    end
  end

  // Pattern/direction after a tick in the current mode.
  always_comb begin
    w_pat_shift = r_pattern;
    w_dir_shift = r_dir;
    case (r_mode)
      ModeBounce: begin
        if (r_dir) begin
          if (r_pattern[WIDTH-1]) begin
            w_dir_shift = 1'b0;
            w_pat_shift = r_pattern >> 1;
          end else begin
            w_pat_shift = r_pattern << 1;
          end
        end else begin
          if (r_pattern[0]) begin
            w_dir_shift = 1'b1;
            w_pat_shift = r_pattern << 1;
          end else begin
            w_pat_shift = r_pattern >> 1;
          end
        end
      end
      ModeRotL: w_pat_shift = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
      ModeRotR: w_pat_shift = {r_pattern[0], r_pattern[WIDTH-1:1]};
      default:  w_pat_shift = r_pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler <= 32'(RESET_PRESCALER);
      r_en        <= 1'b1;
      r_mode      <= ModeBounce;
      r_pattern   <= WIDTH'(1);
      r_dir       <= 1'b1;
      r_steps     <= 16'd0;
      r_q         <= 32'd0;
    end else begin
      if (w_wr_presc) r_prescaler <= w_presc_new;
      if (w_wr_ctrl && bus.write_mask_in[0]) begin
        r_en   <= bus.write_value_in[0];
        r_mode <= bus.write_value_in[2:1];
      end

      if (!r_en || w_en_clear) r_q <= 32'd0;
      else if (w_tick)         r_q <= 32'd0;
      else                     r_q <= r_q + 32'd1;

      // A PATTERN write overrides a coincident tick.
      if (w_wr_pat) begin
        r_pattern <= w_pat_new;
        r_dir     <= 1'b1;
      end else if (w_tick) begin
        r_pattern <= w_pat_shift;
        r_dir     <= w_dir_shift;
      end

      if (w_wr_stat) r_steps <= 16'd0;
      else if (w_tick && (r_mode != ModeHold) && !w_wr_pat) r_steps <= r_steps + 16'd1;
    end
  end

  always_comb begin
    w_pat_ext = '0;
    w_pat_ext[WIDTH-1:0] = r_pattern;
    bus.read_value_out = 32'd0;
    if (bus.sel_in) begin
      case (w_addr)
        2'd0:    bus.read_value_out = r_prescaler;
        2'd1:    bus.read_value_out = {29'd0, r_mode, r_en};
        2'd2:    bus.read_value_out = w_pat_ext;
        default: bus.read_value_out = {r_steps, 15'd0, r_dir};
      endcase
    end
  end

endmodule

// File: tb/tb_kitt_scanner.sv
module tb_kitt_scanner;

  localparam logic [31:0] APresc = 32'h4000_0000;
  localparam logic [31:0] ACtrl  = 32'h4000_0004;
  localparam logic [31:0] APat   = 32'h4000_0008;
  localparam logic [31:0] AStat  = 32'h4000_000C;

  logic       clk;
  logic       reset;
  logic [4:0] display;
  int         checks;
  int         errors;

  kitt_scanner_if bus_if ();

  kitt_scanner #(
    .WIDTH           (5),
    .RESET_PRESCALER (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .display_out (display),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
    bus_if.sel_in         = 1'b1;
    bus_if.address_in     = addr;
    bus_if.write_mask_in  = mask;
    bus_if.write_value_in = data;
    @(posedge clk);
    #1;
    bus_if.sel_in        = 1'b0;
    bus_if.write_mask_in = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic rdy);
    bus_if.sel_in        = 1'b1;
    bus_if.address_in    = addr;
    bus_if.write_mask_in = 4'h0;
    #1;
    data = bus_if.read_value_out;
    rdy  = bus_if.ready_out;
    bus_if.sel_in = 1'b0;
  endtask

  // Disable, program PRESCALER and PATTERN, clear STEPS.
  task automatic setup(input logic [31:0] presc, input logic [4:0] pat);
    bus_write(ACtrl, 4'hF, 32'd0);
    bus_write(APresc, 4'hF, presc);
    bus_write(APat, 4'hF, {27'd0, pat});
    bus_write(AStat, 4'hF, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rdy;
    logic [4:0]  seq [5];
    logic [4:0]  prev;
    seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000};
    reset = 1'b1;
    tick_wait(2);
    reset = 1'b0;
    checks++;
    if (display !== 5'b00001) begin
      errors++; $display("FAIL reset_display: got %b expected %b", display, 5'b00001);
    end
    checks++;
    if (bus_if.ready_out !== 1'b0 || bus_if.read_value_out !== 32'd0) begin
      errors++; $display("FAIL idle_bus: got ready=%b rd=%h expected 0/0",
                         bus_if.ready_out, bus_if.read_value_out);
    end
    bus_read(APresc, rd, rdy);
    checks++;
    if (rd !== 32'd2 || rdy !== 1'b1) begin
      errors++; $display("FAIL reset_presc: got %h rdy=%b expected 2 rdy=1", rd, rdy);
    end
    bus_read(ACtrl, rd, rdy);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 1", rd);
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL reset_status: got %h expected 1", rd);
    end
    prev = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      tick_wait(2);
      checks++;
      if (display !== prev) begin
        errors++; $display("FAIL bounce_hold[%0d]: got %b expected %b", i, display, prev);
      end
      tick_wait(1);
      checks++;
      if (display !== seq[i]) begin
        errors++; $display("FAIL bounce_step[%0d]: got %b expected %b", i, display, seq[i]);
      end
      prev = seq[i];
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'h0005_0000) begin
      errors++; $display("FAIL bounce_status: got %h expected %h", rd, 32'h0005_0000);
    end
  endtask

  task automatic test_rotate();
    logic [31:0] rd;
    logic        rdy;
    logic [4:0]  seq [5];
    seq = '{5'b00110, 5'b01100, 5'b11000, 5'b10001, 5'b00011};
    setup(32'd0, 5'b00011);
    bus_write(ACtrl, 4'hF, 32'd3);
    checks++;
    if (display !== 5'b00011) begin
      errors++; $display("FAIL rotl_start: got %b expected %b", display, 5'b00011);
    end
    for (int i = 0; i < 5; i++) begin
      tick_wait(1);
      checks++;
      if (display !== seq[i]) begin
        errors++; $display("FAIL rotl_step[%0d]: got %b expected %b", i, display, seq[i]);
      end
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'h0005_0001) begin
      errors++; $display("FAIL rotl_status: got %h expected %h", rd, 32'h0005_0001);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd;
    logic        rdy;
    setup(32'h0000_1234, 5'b00001);
    bus_write(APresc, 4'b0001, 32'h0000_00FF);
    bus_read(APresc, rd, rdy);
    checks++;
    if (rd !== 32'h0000_12FF || rdy !== 1'b1) begin
      errors++; $display("FAIL byte_mask: got %h rdy=%b expected 000012ff rdy=1", rd, rdy);
    end
    #1;
    checks++;
    if (bus_if.ready_out !== 1'b0 || bus_if.read_value_out !== 32'd0) begin
      errors++; $display("FAIL ready_drop: got ready=%b rd=%h expected 0/0",
                         bus_if.ready_out, bus_if.read_value_out);
    end
    bus_write(APat, 4'hF, 32'hFFFF_FFE5);
    bus_read(APat, rd, rdy);
    checks++;
    if (rd !== 32'h0000_0005) begin
      errors++; $display("FAIL pattern_upper: got %h expected 5", rd);
    end
    bus_write(ACtrl, 4'hF, 32'hFFFF_FFF6);
    bus_read(ACtrl, rd, rdy);
    checks++;
    if (rd !== 32'h0000_0006) begin
      errors++; $display("FAIL ctrl_upper: got %h expected 6", rd);
    end
  endtask

  task automatic test_pattern_tick();
    logic [31:0] rd;
    logic        rdy;
    setup(32'd0, 5'b01000);
    bus_write(ACtrl, 4'hF, 32'd1);
    bus_write(APat, 4'hF, 32'h0000_0004);
    checks++;
    if (display !== 5'b00100) begin
      errors++; $display("FAIL pat_tick_display: got %b expected %b", display, 5'b00100);
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL pat_tick_status: got %h expected 1", rd);
    end
    tick_wait(1);
    checks++;
    if (display !== 5'b01000) begin
      errors++; $display("FAIL pat_tick_next: got %b expected %b", display, 5'b01000);
    end
  endtask

  task automatic test_enable();
    setup(32'd2, 5'b00001);
    bus_write(ACtrl, 4'hF, 32'd1);
    tick_wait(1);
    bus_write(ACtrl, 4'hF, 32'd0);
    tick_wait(20);
    checks++;
    if (display !== 5'b00001) begin
      errors++; $display("FAIL en_frozen: got %b expected %b", display, 5'b00001);
    end
    bus_write(ACtrl, 4'hF, 32'd1);
    tick_wait(2);
    checks++;
    if (display !== 5'b00001) begin
      errors++; $display("FAIL reen_early: got %b expected %b", display, 5'b00001);
    end
    tick_wait(1);
    checks++;
    if (display !== 5'b00010) begin
      errors++; $display("FAIL reen_tick: got %b expected %b", display, 5'b00010);
    end
  endtask

  task automatic test_prescaler_lower();
    logic [31:0] rd;
    logic        rdy;
    setup(32'd100, 5'b00001);
    bus_write(ACtrl, 4'hF, 32'd1);
    tick_wait(50);
    bus_write(APresc, 4'hF, 32'd10);
    checks++;
    if (display !== 5'b00001) begin
      errors++; $display("FAIL presc_low_pre: got %b expected %b", display, 5'b00001);
    end
    bus_write(AStat, 4'hF, 32'd0);
    checks++;
    if (display !== 5'b00010) begin
      errors++; $display("FAIL presc_low_tick: got %b expected %b", display, 5'b00010);
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL clear_vs_tick: got %h expected 1", rd);
    end
  endtask

  task automatic test_modes();
    logic [31:0] rd;
    logic        rdy;
    logic [4:0]  ones [3];
    ones = '{5'b01111, 5'b11110, 5'b01111};
    setup(32'd0, 5'b11111);
    bus_write(ACtrl, 4'hF, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick_wait(1);
      checks++;
      if (display !== ones[i]) begin
        errors++; $display("FAIL all_ones[%0d]: got %b expected %b", i, display, ones[i]);
      end
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'h0003_0000) begin
      errors++; $display("FAIL all_ones_status: got %h expected %h", rd, 32'h0003_0000);
    end
    setup(32'd0, 5'b00011);
    bus_write(ACtrl, 4'hF, 32'd5);
    tick_wait(1);
    checks++;
    if (display !== 5'b10001) begin
      errors++; $display("FAIL rotr_1: got %b expected %b", display, 5'b10001);
    end
    tick_wait(1);
    checks++;
    if (display !== 5'b11000) begin
      errors++; $display("FAIL rotr_2: got %b expected %b", display, 5'b11000);
    end
    setup(32'd0, 5'b00101);
    bus_write(ACtrl, 4'hF, 32'd7);
    tick_wait(3);
    bus_read(AStat, rd, rdy);
    checks++;
    if (display !== 5'b00101 || rd !== 32'h0000_0001) begin
      errors++; $display("FAIL hold: got %b status=%h expected 00101 status=1", display, rd);
    end
    setup(32'd0, 5'b00000);
    bus_write(ACtrl, 4'hF, 32'd1);
    tick_wait(4);
    bus_read(AStat, rd, rdy);
    checks++;
    if (display !== 5'b00000 || rd !== 32'h0004_0001) begin
      errors++; $display("FAIL zero_pat: got %b status=%h expected 00000 status=00040001",
                         display, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        rdy;
    setup(32'd0, 5'b01000);
    bus_write(ACtrl, 4'hF, 32'd3);
    tick_wait(2);
    bus_if.sel_in         = 1'b1;
    bus_if.address_in     = APresc;
    bus_if.write_mask_in  = 4'hF;
    bus_if.write_value_in = 32'h0000_DEAD;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.sel_in        = 1'b0;
    bus_if.write_mask_in = 4'h0;
    checks++;
    if (display !== 5'b00001) begin
      errors++; $display("FAIL midreset_display: got %b expected %b", display, 5'b00001);
    end
    bus_read(APresc, rd, rdy);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL midreset_presc: got %h expected 2", rd);
    end
    bus_read(ACtrl, rd, rdy);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL midreset_ctrl: got %h expected 1", rd);
    end
    bus_read(AStat, rd, rdy);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL midreset_status: got %h expected 1", rd);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    reset                 = 1'b1;
    bus_if.sel_in         = 1'b0;
    bus_if.address_in     = 32'd0;
    bus_if.write_mask_in  = 4'h0;
    bus_if.write_value_in = 32'd0;
    test_reset();
    test_rotate();
    test_byte_mask();
    test_pattern_tick();
    test_enable();
    test_prescaler_lower();
    test_modes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
